// File: rtl/calendar_disp_sched_if.sv
// rtl/calendar_disp_sched_if.sv - field/handshake/display bundle for calendar_disp_sched
interface calendar_disp_sched_if;
  logic [6:0] YEAR;
  logic [3:0] MONTH;
  logic [4:0] DAY;
  logic [4:0] HOUR;
  logic [5:0] MIN;
  logic [5:0] SEC;
  logic       MODE;
  logic       UPDATE;
  logic       BUSY;
  logic       BCD_VALID;
  logic [7:0] DIGIT;
  logic [7:0] SEG;
`ifdef DISP_BLINK_EN
  logic [7:0] BLINK;

  modport master (
    output YEAR, MONTH, DAY, HOUR, MIN, SEC, MODE, UPDATE, BLINK,
    input  BUSY, BCD_VALID, DIGIT, SEG
  );

  modport slave (
    input  YEAR, MONTH, DAY, HOUR, MIN, SEC, MODE, UPDATE, BLINK,
    output BUSY, BCD_VALID, DIGIT, SEG
  );
`else
  modport master (
    output YEAR, MONTH, DAY, HOUR, MIN, SEC, MODE, UPDATE,
    input  BUSY, BCD_VALID, DIGIT, SEG
  );

  modport slave (
    input  YEAR, MONTH, DAY, HOUR, MIN, SEC, MODE, UPDATE,
    output BUSY, BCD_VALID, DIGIT, SEG
  );
`endif
endinterface

// File: rtl/calendar_disp_sched.sv
// rtl/calendar_disp_sched.sv - shared serial BCD converter feeding an 8-digit 7-segment scanner (optional DISP_BLINK_EN)
module calendar_disp_sched #(
  parameter int SCAN_DIV  = 10000,
  parameter int BLINK_DIV = 50
) (
  input  logic                 CLK,
  input  logic                 RST,
  calendar_disp_sched_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);

  if (SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_param_check
    $error("calendar_disp_sched: SCAN_DIV must be >= 2 and BLINK_DIV >= 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          pending_q, pending_d;
  logic [2:0]    field_q, field_d;
  logic [2:0]    shift_q, shift_d;
  logic [6:0]    bin_q, bin_d;
  logic [7:0]    acc_q, acc_d;
  // snapshot layout: year[32:26] month[25:22] day[21:17] hour[16:12] min[11:6] sec[5:0]
  logic [32:0]   snap_q, snap_d;
  // buffers hold one byte {tens,ones} per field, year in the top byte, sec in the bottom
  logic [47:0]   shadow_q, shadow_d;
  logic [47:0]   disp_q, disp_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    digit_q, digit_d;
  logic [7:0]    seg_q, seg_d;

  logic [6:0]    field_val;
  logic [7:0]    acc_adj;
  logic [7:0]    store_byte;
  logic [2:0]    idx_inc;
  logic [3:0]    code;

`ifdef DISP_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
`endif

  function automatic logic [7:0] seg_decode(input logic [3:0] c);
    case (c)
      4'd0:    seg_decode = 8'h3F;
      4'd1:    seg_decode = 8'h06;
      4'd2:    seg_decode = 8'h5B;
      4'd3:    seg_decode = 8'h4F;
      4'd4:    seg_decode = 8'h66;
      4'd5:    seg_decode = 8'h6D;
      4'd6:    seg_decode = 8'h7D;
      4'd7:    seg_decode = 8'h07;
      4'd8:    seg_decode = 8'h7F;
      4'd9:    seg_decode = 8'h6F;
      4'hF:    seg_decode = 8'h40;
      default: seg_decode = 8'h00;
    endcase
  endfunction

  // select the snapshot field being converted, zero-extended to 7 bits
  always_comb begin
    case (field_q)
      3'd0:    field_val = snap_q[32:26];
      3'd1:    field_val = {3'b000, snap_q[25:22]};
      3'd2:    field_val = {2'b00, snap_q[21:17]};
      3'd3:    field_val = {2'b00, snap_q[16:12]};
      3'd4:    field_val = {1'b0, snap_q[11:6]};
      default: field_val = {1'b0, snap_q[5:0]};
    endcase
  end

  // double-dabble correction; a year of 100+ cannot fit two digits so it shows dashes
  always_comb begin
    acc_adj = acc_q;
    if (acc_q[3:0] >= 4'd5) acc_adj[3:0] = acc_q[3:0] + 4'd3;
    if (acc_q[7:4] >= 4'd5) acc_adj[7:4] = acc_q[7:4] + 4'd3;
    store_byte = (field_q == 3'd0 && snap_q[32:26] >= 7'd100) ? 8'hFF : acc_q;
  end

  // conversion sequencer: snapshot, 9 cycles per field, commit shadow to display at the end
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    field_d   = field_q;
    shift_d   = shift_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    snap_d    = snap_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    case (state_q)
      IDLE: begin
        if (bus.UPDATE || pending_q) begin
          snap_d    = {bus.YEAR, bus.MONTH, bus.DAY, bus.HOUR, bus.MIN, bus.SEC};
          pending_d = 1'b0;
          field_d   = 3'd0;
          busy_d    = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        bin_d   = field_val;
        acc_d   = 8'h00;
        shift_d = 3'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d   = {acc_adj[6:0], bin_q[6]};
        bin_d   = {bin_q[5:0], 1'b0};
        shift_d = shift_q + 3'd1;
        if (shift_q == 3'd6) state_d = STORE;
      end
      STORE: begin
        case (field_q)
          3'd0:    shadow_d[47:40] = store_byte;
          3'd1:    shadow_d[39:32] = store_byte;
          3'd2:    shadow_d[31:24] = store_byte;
          3'd3:    shadow_d[23:16] = store_byte;
          3'd4:    shadow_d[15:8]  = store_byte;
          default: shadow_d[7:0]   = store_byte;
        endcase
        if (field_q == 3'd5) begin
          disp_d  = shadow_d;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          field_d = field_q + 3'd1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && bus.UPDATE) pending_d = 1'b1;
  end

  // nibble for the digit the scanner moves to next, by display mode
  always_comb begin
    idx_inc = idx_q + 3'd1;
    code    = 4'h0;
    if (bus.MODE) begin
      case (idx_inc)
        3'd7: code = 4'd2;
        3'd6: code = 4'd0;
        3'd5: code = disp_q[47:44];
        3'd4: code = disp_q[43:40];
        3'd3: code = disp_q[39:36];
        3'd2: code = disp_q[35:32];
        3'd1: code = disp_q[31:28];
        default: code = disp_q[27:24];
      endcase
    end else begin
      case (idx_inc)
        3'd7: code = disp_q[23:20];
        3'd6: code = disp_q[19:16];
        3'd5: code = 4'hF;
        3'd4: code = disp_q[15:12];
        3'd3: code = disp_q[11:8];
        3'd2: code = 4'hF;
        3'd1: code = disp_q[7:4];
        default: code = disp_q[3:0];
      endcase
    end
  end

  // digit scanner: DIGIT and SEG move together on each prescaler wrap
  always_comb begin
    pre_d   = pre_q + 1'b1;
    idx_d   = idx_q;
    digit_d = digit_q;
    seg_d   = seg_q;
`ifdef DISP_BLINK_EN
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
`endif
    if (pre_q == SCAN_LAST) begin
      pre_d   = '0;
      idx_d   = idx_inc;
      digit_d = ~(8'd1 << idx_inc);
      seg_d   = valid_q ? seg_decode(code) : 8'h00;
`ifdef DISP_BLINK_EN
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
      end
      if (phase_d && bus.BLINK[idx_inc]) seg_d = 8'h00;
`endif
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      field_q   <= 3'd0;
      shift_q   <= 3'd0;
      bin_q     <= 7'd0;
      acc_q     <= 8'h00;
      snap_q    <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pre_q     <= '0;
      idx_q     <= 3'd0;
      digit_q   <= 8'hFE;
      seg_q     <= 8'h00;
`ifdef DISP_BLINK_EN
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      field_q   <= field_d;
      shift_q   <= shift_d;
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      snap_q    <= snap_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      digit_q   <= digit_d;
      seg_q     <= seg_d;
`ifdef DISP_BLINK_EN
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
`endif
    end
  end

  assign bus.BUSY      = busy_q;
  assign bus.BCD_VALID = valid_q;
  assign bus.DIGIT     = digit_q;
  assign bus.SEG       = seg_q;

endmodule

// File: doc/calendar_disp_sched.md
Name: calendar_disp_sched

Overview:
Scheduler and display controller for the term-project clock/calendar. It shares one serial binary-to-BCD digit separator (double-dabble) among six time/date fields. The converted digits go into a coherent display buffer. The block then time-multiplexes an 8-digit 7-segment display, showing either the date ("20YYMMDD") or the time ("HH-MM-SS"). It sits between the clock/calendar counters and the board's 7-segment pins.

Parameters:
SCAN_DIV, 10000, CLK cycles per digit scan step (>=2)
BLINK_DIV, 50, scan steps per blink phase (used only with DISP_BLINK_EN)

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
YEAR  in  7  two-digit year, 0-99 valid
MONTH  in  4  month, 1-12
DAY  in  5  day, 1-31
HOUR  in  5  hour, 0-23
MIN  in  6  minute, 0-59
SEC  in  6  second, 0-59
MODE  in  1  0 = time display, 1 = date display
UPDATE  in  1  request conversion of current field values (level or pulse)
BUSY  out  1  conversion sequence in progress
BCD_VALID  out  1  display buffer holds at least one completed conversion
DIGIT  out  8  digit select, one-hot, active-low; bit 7 = leftmost digit
SEG  out  8  segments {dp,g,f,e,d,c,b,a}, active-high

Behaviour:
- Interface: single clock CLK; RST synchronous, active-high. All outputs are registered.
- Reset values:
  - FSM=IDLE; BUSY=0; BCD_VALID=0; pending=0.
  - Scan prescaler=0; scan index=0.
  - DIGIT=8'hFE; SEG=8'h00.
  - All buffer nibbles=0.
- Conversion FSM states: IDLE, LOAD, SHIFT, STORE.
- Accept: in IDLE, if UPDATE=1 or pending=1 at edge t:
  - snapshot all six inputs;
  - clear pending;
  - go to LOAD with field index 0.
- Field order: YEAR, MONTH, DAY, HOUR, MIN, SEC.
- Per field (9 cycles):
  - LOAD: zero-extend the field to 7 bits; clear the 8-bit BCD accumulator.
  - SHIFT x7, MSB first: add 3 to each BCD nibble >=5, then shift left by one.
  - STORE: write tens/ones to the shadow buffer; advance to the next field's LOAD.
  - After SEC's STORE: copy shadow to display buffer in one edge; set BCD_VALID=1; return to IDLE.
- Latency and BUSY:
  - BUSY=1 for cycles t+1..t+54 exactly.
  - Display buffer and BCD_VALID update at the end of t+54, so they are visible in t+55.
- Out-of-range field: snapshot value >=100 (YEAR only) stores tens=ones=4'hF (dash code). Timing is unchanged (still 9 cycles).
- Other out-of-range values (e.g. MONTH=0) are converted literally; no clipping.
- UPDATE while BUSY: sets pending. Pending is served on the first IDLE cycle, giving exactly one BUSY-low cycle (t+55). Multiple requests collapse into one.
- Display buffer changes only at commit, so the display never shows a partially converted set.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - At terminal count: index <= index+1 mod 8; DIGIT <= ~(1<<index_next); SEG <= decode(nibble for index_next).
  - SEG and DIGIT change on the same edge.
- Digit map, index 7 down to 0:
  - MODE=1 (date): 2, 0, Y10, Y1, Mo10, Mo1, D10, D1.
  - MODE=0 (time): H10, H1, dash, Mi10, Mi1, dash, S10, S1.
- MODE is sampled at each scan step; a MODE change takes effect on the next scan step.
- Decode:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 4'hF (dash) = 40.
  - Any other code = 00.
  - dp is always 0.
- While BCD_VALID=0, SEG=00 (blank). DIGIT keeps scanning.
- RST mid-conversion: immediate return to reset state; display buffer cleared; BCD_VALID=0.

Optional Feature:
DISP_BLINK_EN:
- Defined:
  - adds input BLINK[7:0] (per-digit blink mask, bit i = digit index i);
  - a counter of scan steps toggles a blink phase every BLINK_DIV steps (phase=0 at reset);
  - when phase=1 and BLINK[index]=1, SEG=00 for that digit step.
- Not defined: BLINK port absent; no blanking logic; SEG behaviour as above.

Test Plan:
- RST held 3 cycles -> DIGIT=FE, SEG=00, BUSY=0, BCD_VALID=0. Scan continues, SEG stays 00.
- YEAR=20, MONTH=12, DAY=7, HOUR=13, MIN=5, SEC=59, single-cycle UPDATE at t -> BUSY high t+1..t+54; BCD_VALID=1 at t+55.
  - MODE=1, SCAN_DIV=4: SEG sequence over indices 7..0 = 5B,3F,5B,3F,06,5B,3F,07.
  - MODE=0: SEG sequence = 06,4F,40,3F,6D,40,6D,6F.
- YEAR=120, UPDATE -> year digits both 40 after commit; other fields converted normally; latency still 54.
- UPDATE at t, change SEC 59->0 at t+10, UPDATE at t+20 -> first commit shows old snapshot. BUSY low only at t+55. Second commit at t+109 shows S10=S1=3F.
- RST asserted at t+30 of a conversion -> BUSY=0, BCD_VALID=0, SEG=00 next cycle. No commit occurs.
- DISP_BLINK_EN, BLINK_DIV=2, BLINK=8'h03, SCAN_DIV=4 -> digits 1,0 blank on alternating 2-step phases; digits 7..2 never blank.
